// File: rtl/uart_tty_monitor.sv
// UART terminal endpoint: deserializes the SoC TX line into bytes with error flags and
// serializes host bytes onto the SoC RX line. RX and TX run independently.
module uart_tty_monitor #(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       srx_i,
    output logic       stx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_newline_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);
    localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam bit ParEn  = (PARITY_MODE != 0);
    localparam bit ParOdd = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitIdle
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxParity, TxStop
    } tx_state_e;

    // ---------------- Receiver ----------------
    rx_state_e       rx_state_q;
    logic [1:0]      rx_sync_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_par_bad_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            rx_perr_q;
    logic            rx_ferr_q;
    logic            rx_newline_q;
    logic            rx_line;

    assign rx_line = rx_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q   <= RxIdle;
            rx_sync_q    <= 2'b11;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bad_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_newline_q <= 1'b0;
        end else begin
            rx_sync_q    <= {rx_sync_q[0], srx_i};
            rx_valid_q   <= 1'b0;
            rx_newline_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    rx_par_bad_q <= 1'b0;
                    if (!rx_line) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        rx_state_q <= rx_line ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_line, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= ParEn ? RxParity : RxStop;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxParity: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q     <= '0;
                        rx_par_bad_q <= ((^{rx_shift_q, rx_line}) != ParOdd);
                        rx_state_q   <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q     <= '0;
                        rx_valid_q   <= 1'b1;
                        rx_data_q    <= rx_shift_q;
                        rx_newline_q <= (rx_shift_q == 8'h0A);
                        rx_perr_q    <= ParEn && rx_par_bad_q;
                        rx_ferr_q    <= !rx_line;
                        rx_state_q   <= rx_line ? RxIdle : RxWaitIdle;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxWaitIdle: begin
                    if (rx_line) begin
                        rx_state_q <= RxIdle;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_parity_err_o = rx_perr_q;
    assign rx_frame_err_o  = rx_ferr_q;
    assign rx_newline_o    = rx_newline_q;

    // ---------------- Transmitter ----------------
    tx_state_e       tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_par_q;
    logic            tx_line_q;
    logic            tx_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_valid_i && tx_ready_q) begin
                        tx_shift_q <= tx_data_i;
                        tx_par_q   <= (^tx_data_i) ^ ParOdd;
                        tx_line_q  <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_line_q  <= ParEn ? tx_par_q : 1'b1;
                            tx_state_q <= ParEn ? TxParity : TxStop;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_line_q  <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TxParity: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q   <= '0;
                        tx_line_q  <= 1'b1;
                        tx_state_q <= TxStop;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q   <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= TxIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign stx_o      = tx_line_q;
    assign tx_ready_o = tx_ready_q;

endmodule

// File: tb/tb_uart_tty_monitor.sv
// Directed bench for uart_tty_monitor: one instance without parity (RX, TX, loopback, reset)
// and one with even parity for the parity-error cases.
module tb_uart_tty_monitor;
    localparam int Cpb = 217;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       loop_en;
    logic       srx_drv0, srx_drv1;
    logic       srx0;
    logic       stx0, stx1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       rx_perr0, rx_perr1;
    logic       rx_ferr0, rx_ferr1;
    logic       rx_nl0, rx_nl1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready0, tx_ready1;

    assign srx0 = loop_en ? stx0 : srx_drv0;

    uart_tty_monitor #(.CLK_FREQ_HZ(25000000), .BAUD_RATE(115200), .PARITY_MODE(0)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .srx_i           (srx0),
        .stx_o           (stx0),
        .rx_data_o       (rx_data0),
        .rx_valid_o      (rx_valid0),
        .rx_parity_err_o (rx_perr0),
        .rx_frame_err_o  (rx_ferr0),
        .rx_newline_o    (rx_nl0),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready0)
    );

    uart_tty_monitor #(.CLK_FREQ_HZ(25000000), .BAUD_RATE(115200), .PARITY_MODE(1)) dut_p (
        .clk_i           (clk),
        .rst_i           (rst),
        .srx_i           (srx_drv1),
        .stx_o           (stx1),
        .rx_data_o       (rx_data1),
        .rx_valid_o      (rx_valid1),
        .rx_parity_err_o (rx_perr1),
        .rx_frame_err_o  (rx_ferr1),
        .rx_newline_o    (rx_nl1),
        .tx_data_i       (8'h00),
        .tx_valid_i      (1'b0),
        .tx_ready_o      (tx_ready1)
    );

    int tests = 0;
    int fails = 0;

    // Receive monitors: record every valid pulse away from the active edge.
    int         rx_cnt0 = 0;
    int         rx_cnt1 = 0;
    logic [7:0] cap0_data [0:15];
    logic       last0_perr, last0_ferr, last0_nl;
    logic [7:0] last1_data;
    logic       last1_perr;

    always @(negedge clk) begin
        if (rx_valid0) begin
            cap0_data[rx_cnt0[3:0]] <= rx_data0;
            last0_perr <= rx_perr0;
            last0_ferr <= rx_ferr0;
            last0_nl   <= rx_nl0;
            rx_cnt0    <= rx_cnt0 + 1;
        end
        if (rx_valid1) begin
            last1_data <= rx_data1;
            last1_perr <= rx_perr1;
            rx_cnt1    <= rx_cnt1 + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) srx_drv0 = b;
        else            srx_drv1 = b;
        tick(Cpb);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (par_en) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (tx_ready0 !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        check(tag, 32'(tx_ready0), 32'd1);
    endtask

    initial begin
        int         n;
        logic       bad;
        logic [9:0] exp_bits;

        rst      = 1'b1;
        loop_en  = 1'b0;
        srx_drv0 = 1'b1;
        srx_drv1 = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick(3);

        check("reset_stx",     32'(stx0),      32'd1);
        check("reset_ready",   32'(tx_ready0), 32'd1);
        check("reset_rx_data", 32'(rx_data0),  32'h00);
        check("reset_valid",   32'(rx_valid0), 32'd0);
        check("reset_perr",    32'(rx_perr0),  32'd0);
        check("reset_ferr",    32'(rx_ferr0),  32'd0);
        check("reset_newline", 32'(rx_nl0),    32'd0);
        rst = 1'b0;
        tick(5);

        // Plain byte 0x55.
        n = rx_cnt0;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        tick(50);
        check("rx55_count", rx_cnt0, n + 1);
        check("rx55_data",  32'(cap0_data[n[3:0]]), 32'h55);
        check("rx55_perr",  32'(last0_perr), 32'd0);
        check("rx55_ferr",  32'(last0_ferr), 32'd0);
        check("rx55_nl",    32'(last0_nl),   32'd0);

        // Transmit 0x48: 0,0,0,0,1,0,0,1,0,1 with ready low throughout.
        exp_bits = {1'b1, 8'h48, 1'b0};
        tx_data  = 8'h48;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int c = 0; c < Cpb; c++) begin
                if (stx0 !== exp_bits[b] || tx_ready0 !== 1'b0) bad = 1'b1;
                tick();
            end
            check($sformatf("tx48_bit%0d_bad", b), 32'(bad), 32'd0);
        end
        check("tx48_ready_back", 32'(tx_ready0), 32'd1);
        check("tx48_line_idle",  32'(stx0),      32'd1);

        // Short glitch, then newline byte.
        n = rx_cnt0;
        srx_drv0 = 1'b0;
        tick(50);
        srx_drv0 = 1'b1;
        tick(400);
        check("glitch_no_valid", rx_cnt0, n);
        send_frame(0, 8'h0A, 1'b0, 1'b0, 1'b1);
        tick(50);
        check("rx0a_count", rx_cnt0, n + 1);
        check("rx0a_data",  32'(cap0_data[n[3:0]]), 32'h0A);
        check("rx0a_nl",    32'(last0_nl), 32'd1);

        // Framing error, line held low, then clean 0x41.
        n = rx_cnt0;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick(20);
        check("rx3c_count", rx_cnt0, n + 1);
        check("rx3c_data",  32'(cap0_data[n[3:0]]), 32'h3C);
        check("rx3c_ferr",  32'(last0_ferr), 32'd1);
        tick(2400);
        check("low_line_no_valid", rx_cnt0, n + 1);
        srx_drv0 = 1'b1;
        tick(300);
        send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
        tick(50);
        check("rx41_count", rx_cnt0, n + 2);
        check("rx41_data",  32'(cap0_data[(n + 1) & 15]), 32'h41);
        check("rx41_ferr",  32'(last0_ferr), 32'd0);
        check("rx41_ferr_hold", 32'(rx_ferr0), 32'd0);

        // Even parity: 0x07 has odd weight, so parity bit 1 is correct.
        n = rx_cnt1;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        tick(50);
        check("par_good_count", rx_cnt1, n + 1);
        check("par_good_data",  32'(last1_data), 32'h07);
        check("par_good_perr",  32'(last1_perr), 32'd0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(50);
        check("par_bad_count", rx_cnt1, n + 2);
        check("par_bad_perr",  32'(last1_perr), 32'd1);

        // Loopback: two back-to-back bytes, reset during the third.
        loop_en = 1'b1;
        tick(10);
        n = rx_cnt0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h0A;
        wait_ready("loop_ready1");
        tick();
        check("loop_second_accepted", 32'(tx_ready0), 32'd0);
        tx_data = 8'h33;
        wait_ready("loop_ready2");
        tick();
        tx_valid = 1'b0;
        tick(1000);
        rst = 1'b1;
        tick();
        check("loop_rst_stx",   32'(stx0),      32'd1);
        check("loop_rst_ready", 32'(tx_ready0), 32'd1);
        rst = 1'b0;
        tick(3000);
        check("loop_count",   rx_cnt0, n + 2);
        check("loop_first",   32'(cap0_data[n[3:0]]),      32'hA5);
        check("loop_second",  32'(cap0_data[(n + 1) & 15]), 32'h0A);
        check("loop_nl",      32'(last0_nl), 32'd1);
        check("loop_rx_data_after_rst", 32'(rx_data0), 32'h00);
        check("loop_idle_ready", 32'(tx_ready0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tty_monitor.md
Name: uart_tty_monitor

Overview:
- Synthesizable UART terminal endpoint attached to the SoC UART pads.
- Deserializes the SoC transmit line (`srx_i`) into bytes and reports each byte with a one-cycle valid pulse and error flags.
- Serializes host-supplied bytes onto the SoC receive line (`stx_o`).
- Serves as the console/stimulus endpoint in system-level benches and on FPGA bring-up boards.

Parameters:
- `CLK_FREQ_HZ`, 25000000: frequency of `clk_i` in Hz.
- `BAUD_RATE`, 115200: line rate in bits/s. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, integer-truncated (217 at defaults).
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd. Applies to both RX and TX.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `srx_i`  in  1  serial line from SoC TX pad; asynchronous to `clk_i`; idle high.
- `stx_o`  out  1  serial line to SoC RX pad; idle high.
- `rx_data_o`  out  8  last received byte.
- `rx_valid_o`  out  1  one-cycle pulse: `rx_data_o` and the error flags are valid.
- `rx_parity_err_o`  out  1  parity mismatch on the current byte; valid with `rx_valid_o`.
- `rx_frame_err_o`  out  1  stop bit sampled low; valid with `rx_valid_o`.
- `rx_newline_o`  out  1  pulses with `rx_valid_o` when the byte is 0x0A.
- `tx_data_i`  in  8  byte to send.
- `tx_valid_i`  in  1  send request.
- `tx_ready_o`  out  1  transmitter idle and able to accept a byte.

Behaviour:
- **Reset values:** `stx_o`=1, `tx_ready_o`=1, `rx_data_o`=0x00, `rx_valid_o`=0, both error flags 0, `rx_newline_o`=0. Both FSMs go to IDLE, counters clear, synchronizer flops preset to 1. Reset mid-frame aborts the frame immediately with no partial output.
- **RX synchronization:** `srx_i` passes through 2 flops (sync); all RX decisions use the sync output.
- **RX FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE:** a sync value of 0 moves to START and clears the bit counter.
- **START:** after `CLKS_PER_BIT/2` cycles (108), sample. If 0 → DATA. If 1 → glitch, return to IDLE with no output.
- **DATA:** sample every `CLKS_PER_BIT` cycles; 8 bits, LSB first, shifted into an internal register. Then go to PARITY if `PARITY_MODE`≠0, else STOP.
- **PARITY:** sample one bit. Even mode: error if XOR(data, parity bit) ≠ 0. Odd mode: error if that XOR ≠ 1.
- **STOP:** sample one bit. In the following cycle, drive `rx_valid_o`=1 for exactly one cycle, update `rx_data_o`, and set the error flags for this byte.
  - Stop bit = 1 → IDLE.
  - Stop bit = 0 → set `rx_frame_err_o`, go to WAIT_IDLE. Stay there until sync = 1, then go to IDLE; no start detection meanwhile.
- **Error flags and newline:** error flags hold their value until the next `rx_valid_o`. `rx_newline_o` = `rx_valid_o` AND data==0x0A, reported regardless of error flags.
- **TX FSM states:** IDLE, START, DATA, PARITY, STOP.
- **TX accept:** a byte is accepted when `tx_valid_i` && `tx_ready_o`. `tx_ready_o` drops the next cycle. `tx_valid_i` while not ready is ignored; no queuing.
- **TX frame:** start bit 0, 8 data bits LSB first, optional parity bit (even/odd per `PARITY_MODE`), then 1 stop bit of 1. Every bit is held exactly `CLKS_PER_BIT` cycles. `stx_o` is registered.
- **TX completion:** `tx_ready_o` returns to 1 in the cycle after the stop bit's last cycle. Back-to-back sends are allowed: a byte accepted that same cycle starts its start bit on the next cycle.
- **Frame length:** 10 bits = 2170 cycles without parity, 11 bits = 2387 with parity.
- **Independence:** RX and TX run concurrently and independently; loopback (`stx_o` tied to `srx_i`) must work.

Test Plan:
- 0x55 driven on `srx_i` at 217 cycles/bit, `PARITY_MODE`=0 → one `rx_valid_o` pulse, `rx_data_o`=0x55, both errors 0, `rx_newline_o`=0.
- `tx_data_i`=0x48 with `tx_valid_i` pulse → `stx_o` shows bits 0,0,0,0,1,0,0,1,0,1, each 217 cycles; `tx_ready_o` low 2170 cycles.
- `srx_i` low for 50 cycles then high → no `rx_valid_o`; a subsequent 0x0A frame → `rx_data_o`=0x0A, `rx_newline_o` pulses.
- Frame 0x3C with stop bit low → `rx_frame_err_o`=1. A start edge while the line is still low is ignored; after the line returns high, 0x41 is received cleanly with `rx_frame_err_o`=0.
- `PARITY_MODE`=1, byte 0x07 with parity bit 1 → `rx_parity_err_o`=0; same byte with parity bit 0 → `rx_parity_err_o`=1.
- Loopback `stx_o`→`srx_i`: send 0xA5 then 0x0A back-to-back, then assert `rst_i` mid-third frame → 0xA5 and 0x0A received. After reset: `stx_o`=1, `tx_ready_o`=1 the next cycle, no third `rx_valid_o`.
